// File: rtl/grid_framebuffer.sv
`default_nettype none
// ============================================================================
// Module      : grid_framebuffer
// Description : Character-cell framebuffer with a write port, a registered
//               scan-out read port and a full-grid fill sweep (also run after
//               reset). Optional macro GRID_FB_XOR_WRITE_EN adds XOR writes.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_framebuffer #(
    parameter int GRID_ROWS = 30,
    parameter int GRID_COLS = 40,
    parameter int CELL_BITS = 2,
    localparam int RW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1,
    localparam int CW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [RW-1:0]        wr_row,
    input  logic [CW-1:0]        wr_col,
    input  logic [CELL_BITS-1:0] wr_data,
`ifdef GRID_FB_XOR_WRITE_EN
    input  logic                 wr_xor,
`endif
    input  logic                 clr_req,
    input  logic [CELL_BITS-1:0] clr_value,
    output logic                 busy,
    output logic                 clr_done,
    output logic                 err_oob,
    input  logic [RW-1:0]        rd_row,
    input  logic [CW-1:0]        rd_col,
    output logic [CELL_BITS-1:0] rd_data
);

    localparam int                c_cells  = GRID_ROWS * GRID_COLS;
    localparam int                c_aw     = (c_cells > 1) ? $clog2(c_cells) : 1;
    localparam logic [c_aw-1:0]   c_last   = c_aw'(c_cells - 1);
    localparam logic [c_aw-1:0]   c_cols_a = c_aw'(GRID_COLS);
    localparam logic [RW:0]       c_rows   = (RW + 1)'(GRID_ROWS);
    localparam logic [CW:0]       c_cols   = (CW + 1)'(GRID_COLS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_aw-1:0]        r_cnt;
    logic [CELL_BITS-1:0]   r_fill;
    logic [CELL_BITS-1:0]   r_mem [c_cells];
    logic [CELL_BITS-1:0]   r_rd_data;
    logic                   r_clr_done;
    logic                   r_err_oob;

    logic                   w_last;
    logic                   w_wr_fire;
    logic                   w_wr_in_range;
    logic                   w_wr_we;
    logic                   w_fill_we;
    logic [c_aw-1:0]        w_wr_addr;
    logic [CELL_BITS-1:0]   w_wr_value;
    logic                   w_rd_in_range;
    logic [c_aw-1:0]        w_rd_addr;

    assign wr_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_FILL);
    assign clr_done = r_clr_done;
    assign err_oob  = r_err_oob;
    assign rd_data  = r_rd_data;

    assign w_last        = (r_cnt == c_last);
    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_wr_in_range = ({1'b0, wr_row} < c_rows) && ({1'b0, wr_col} < c_cols);
    assign w_wr_addr     = c_aw'(wr_row) * c_cols_a + c_aw'(wr_col);
    assign w_rd_in_range = ({1'b0, rd_row} < c_rows) && ({1'b0, rd_col} < c_cols);
    assign w_rd_addr     = c_aw'(rd_row) * c_cols_a + c_aw'(rd_col);

    // Storage is never written while reset is held, so a sweep or write in
    // flight when reset arrives is simply abandoned.
    assign w_fill_we = busy && reset_n;
    assign w_wr_we   = w_wr_fire && w_wr_in_range && reset_n;

`ifdef GRID_FB_XOR_WRITE_EN
    assign w_wr_value = wr_xor ? (r_mem[w_wr_addr] ^ wr_data) : wr_data;
`else
    assign w_wr_value = wr_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_req) w_state_nxt = S_FILL;
            S_FILL:  if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Fill colour is captured only on entry; clr_req during a sweep is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_fill <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
            if (clr_req) r_fill <= clr_value;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + c_aw'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_done <= 1'b0;
            r_err_oob  <= 1'b0;
        end else begin
            r_clr_done <= (r_state == S_FILL) && w_last;
            r_err_oob  <= w_wr_fire && !w_wr_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_mem[r_cnt] <= r_fill;
        end else if (w_wr_we) begin
            r_mem[w_wr_addr] <= w_wr_value;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (busy || !w_rd_in_range) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grid_framebuffer.sv
`default_nettype none
// Self-checking bench for grid_framebuffer: directed steps plus randomized
// writes/reads against a 2-D array model of the grid.
module tb_grid_framebuffer;

    localparam int ROWS  = 30;
    localparam int COLS  = 40;
    localparam int CB    = 2;
    localparam int RW    = 5;
    localparam int CW    = 6;
    localparam int CELLS = ROWS * COLS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [RW-1:0] wr_row = '0;
    logic [CW-1:0] wr_col = '0;
    logic [CB-1:0] wr_data = '0;
    logic          wr_xor = 1'b0;
    logic          clr_req = 1'b0;
    logic [CB-1:0] clr_value = '0;
    logic [RW-1:0] rd_row = '0;
    logic [CW-1:0] rd_col = '0;
    logic          wr_ready;
    logic          busy;
    logic          clr_done;
    logic          err_oob;
    logic [CB-1:0] rd_data;

    int checks   = 0;
    int failures = 0;
    logic [CB-1:0] model [ROWS][COLS];

    grid_framebuffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
`ifdef GRID_FB_XOR_WRITE_EN
        .wr_xor    (wr_xor),
`endif
        .clr_req   (clr_req),
        .clr_value (clr_value),
        .busy      (busy),
        .clr_done  (clr_done),
        .err_oob   (err_oob),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_fill(input int v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = CB'(v);
    endtask

    task automatic model_write(input int r, input int c, input int d, input bit x);
        bit xe;
`ifdef GRID_FB_XOR_WRITE_EN
        xe = x;
`else
        xe = 1'b0;
`endif
        if (r < ROWS && c < COLS)
            model[r][c] = xe ? (model[r][c] ^ CB'(d)) : CB'(d);
    endtask

    function automatic int model_read(input int r, input int c);
        return (r < ROWS && c < COLS) ? int'(model[r][c]) : 0;
    endfunction

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic write_cell(input int r, input int c, input int d, input bit x);
        wr_valid = 1'b1;
        wr_row   = RW'(r);
        wr_col   = CW'(c);
        wr_data  = CB'(d);
        wr_xor   = x;
        @(negedge clk);
        wr_valid = 1'b0;
        model_write(r, c, d, x);
    endtask

    task automatic read_cell(input string tag, input int r, input int c);
        rd_row = RW'(r);
        rd_col = CW'(c);
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(model_read(r, c)));
    endtask

    task automatic scan(input string tag);
        int mism = 0;
        for (int i = 0; i <= CELLS; i++) begin
            if (i > 0 && rd_data !== model[(i - 1) / COLS][(i - 1) % COLS]) mism++;
            if (i < CELLS) begin
                rd_row = RW'(i / COLS);
                rd_col = CW'(i % COLS);
            end
            @(negedge clk);
        end
        check({tag, "_mismatches"}, 32'(mism), 32'd0);
    endtask

    // Counts busy-high samples until the sweep ends; optionally injects a
    // clr_req plus write attempt at sample inject_at, both of which must be ignored.
    task automatic wait_sweep(input string tag, input int inject_at);
        int cnt = 0;
        int rdybad = 0;
        int rdbad = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            if (wr_ready !== 1'b0) rdybad++;
            if (cnt >= 1 && rd_data !== '0) rdbad++;
            cnt++;
            if (cnt == inject_at) begin
                clr_req   = 1'b1;
                clr_value = 2'd1;
                wr_valid  = 1'b1;
                wr_row    = 5'd2;
                wr_col    = 6'd2;
                wr_data   = 2'd3;
            end else begin
                clr_req  = 1'b0;
                wr_valid = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(CELLS));
        check({tag, "_ready_low"}, 32'(rdybad), 32'd0);
        check({tag, "_rd_zero_busy"}, 32'(rdbad), 32'd0);
        check({tag, "_clr_done"}, 32'(clr_done), 32'd1);
        check({tag, "_ready_after"}, 32'(wr_ready), 32'd1);
        @(negedge clk);
        check({tag, "_clr_done_once"}, 32'(clr_done), 32'd0);
    endtask

    initial begin
        int r, c, d, rr, rc, exp_rd;
        bit x, exp_oob;

        // Power-on reset
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        check("rst_clr_done", 32'(clr_done), 32'd0);
        check("rst_err", 32'(err_oob), 32'd0);
        reset_n = 1'b1;
        model_fill(0);
        wait_sweep("por", 0);
        read_cell("por_rd_0_0", 0, 0);
        read_cell("por_rd_29_39", 29, 39);

        // Basic write and read-after-write
        write_cell(5, 7, 3, 1'b0);
        check("w57_err", 32'(err_oob), 32'd0);
        read_cell("rd_5_7", 5, 7);
        check("rd_5_7_val", 32'(rd_data), 32'd3);
        read_cell("rd_5_8", 5, 8);

        // Out-of-range writes
        write_cell(30, 0, 1, 1'b0);
        check("oob_row_pulse", 32'(err_oob), 32'd1);
        @(negedge clk);
        check("oob_row_once", 32'(err_oob), 32'd0);
        read_cell("rd_30_0", 30, 0);
        write_cell(0, 40, 2, 1'b0);
        check("oob_col_pulse", 32'(err_oob), 32'd1);
        scan("oob_scan");

        // Randomized writes with concurrent reads
        for (int i = 0; i < 150; i++) begin
            r  = int'($urandom_range(0, 31));
            c  = int'($urandom_range(0, 47));
            d  = int'($urandom_range(0, 3));
            x  = 1'($urandom_range(0, 1));
            rr = int'($urandom_range(0, 31));
            rc = int'($urandom_range(0, 47));
            exp_rd  = model_read(rr, rc);
            exp_oob = !(r < ROWS && c < COLS);
            rd_row  = RW'(rr);
            rd_col  = CW'(rc);
            write_cell(r, c, d, x);
            check("rnd_oob", 32'(err_oob), 32'(exp_oob));
            check("rnd_rd", 32'(rd_data), 32'(exp_rd));
        end
        wr_xor = 1'b0;
        scan("rnd_scan");

        // Fill with coincident write, second clr_req mid-sweep ignored
        clr_req   = 1'b1;
        clr_value = 2'd2;
        wr_valid  = 1'b1;
        wr_row    = 5'd1;
        wr_col    = 6'd1;
        wr_data   = 2'd1;
        @(negedge clk);
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        model_write(1, 1, 1, 1'b0);
        model_fill(2);
        check("fill2_busy", 32'(busy), 32'd1);
        wait_sweep("fill2", 600);
        scan("fill2_scan");

        // XOR write (overwrite without the macro)
        write_cell(0, 1, 1, 1'b0);
        write_cell(0, 1, 3, 1'b1);
        read_cell("xor_rd", 0, 1);

        // Reset in the middle of a sweep
        clr_req   = 1'b1;
        clr_value = 2'd3;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (600) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_ready", 32'(wr_ready), 32'd0);
        check("midrst_rd", 32'(rd_data), 32'd0);
        check("midrst_clr_done", 32'(clr_done), 32'd0);
        reset_n = 1'b1;
        model_fill(0);
        wait_sweep("midrst", 0);
        scan("midrst_scan");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
